// File: rtl/dec_2_sync.sv
// dec_2_sync: 2-to-4 decoder behind a valid/ready FIFO. Words are decoded
// to one-hot on write. A saturating counter tracks accepted null (V=0) words.
module dec_2_sync #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             x,
    input  logic             y,
    input  logic             V,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             D0,
    output logic             D1,
    output logic             D2,
    output logic             D3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] null_cnt,
    input  logic             cnt_clr
);
    localparam int AW = $clog2(DEPTH);
    logic [3:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] null_q, null_d;
    logic             push, pop;
    logic [3:0]       word;
    assign in_ready  = rst_n & (cnt_q != (AW+1)'(DEPTH));
    assign out_valid = cnt_q != '0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign word      = V ? 4'b0001 << {x, y} : 4'b0000;
    assign {D3, D2, D1, D0} = out_valid ? mem_q[rd_q] : 4'b0000;
    assign null_cnt  = null_q;
    always_comb begin
        wr_d   = push ? wr_q + AW'(1) : wr_q;
        rd_d   = pop ? rd_q + AW'(1) : rd_q;
        cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        null_d = cnt_clr ? '0 : (push & ~V & ~&null_q) ? null_q + CNT_W'(1) : null_q;
    end
    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= word;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            null_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            null_q <= null_d;
        end
    end
endmodule

// File: tb/tb_dec_2_sync.sv
// tb_dec_2_sync: directed scenarios plus random traffic checked against a
// queue-based model of the decoder FIFO and null-word counter.
module tb_dec_2_sync;
    localparam int DEPTH = 2;
    localparam int CNT_W = 3;
    localparam int NMAX  = (1 << CNT_W) - 1;
    logic clk = 0, rst_n = 0, x = 0, y = 0, V = 0, in_valid = 0, out_ready = 0, cnt_clr = 0;
    logic in_ready, out_valid, D0, D1, D2, D3;
    logic [CNT_W-1:0] null_cnt;
    logic [3:0] q[$];
    int mcnt = 0;
    int checks = 0, passed = 0;

    dec_2_sync #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .V(V),
        .in_valid(in_valid), .in_ready(in_ready),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3),
        .out_valid(out_valid), .out_ready(out_ready),
        .null_cnt(null_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] exp_d();
        return q.size() != 0 ? q[0] : 4'b0000;
    endfunction

    // Advance one clock and apply the reference rules to the model.
    task automatic tick();
        bit mpush, mpop;
        int k;
        mpush = rst_n && in_valid && q.size() < DEPTH;
        mpop  = rst_n && out_ready && q.size() != 0;
        k = 2 * int'(x) + int'(y);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            mcnt = 0;
        end else begin
            if (mpop) void'(q.pop_front());
            if (mpush) q.push_back(V ? 4'(1 << k) : 4'b0000);
            if (cnt_clr) mcnt = 0;
            else if (mpush && !V && mcnt < NMAX) mcnt++;
        end
        #1;
    endtask

    task automatic drive(input logic iv, input logic [2:0] xyv);
        in_valid = iv;
        {x, y, V} = xyv;
    endtask

    task automatic test_reset();
        rst_n = 0;
        out_ready = 1;
        drive(1, 3'b111);
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready);
        else passed++;
        tick();
        tick();
        checks++;
        if ({out_valid, D3, D2, D1, D0, null_cnt} !== {5'b00000, 3'd0})
            $display("FAIL reset_state: got v=%b d=%b n=%0d want v=0 d=0000 n=0",
                     out_valid, {D3, D2, D1, D0}, null_cnt);
        else passed++;
        rst_n = 1;
        drive(0, 3'b000);
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_single();
        logic [2:0] codes [4] = '{3'b001, 3'b011, 3'b101, 3'b111};
        logic [3:0] want  [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            drive(1, codes[i]);
            tick();
            drive(0, 3'b000);
            checks++;
            if ({out_valid, D3, D2, D1, D0} !== {1'b1, want[i]})
                $display("FAIL single_%0d: got v=%b d=%b want v=1 d=%b",
                         i, out_valid, {D3, D2, D1, D0}, want[i]);
            else passed++;
            tick();
        end
        checks++;
        if ({out_valid, null_cnt} !== {1'b0, 3'd0})
            $display("FAIL single_end: got v=%b n=%0d want v=0 n=0", out_valid, null_cnt);
        else passed++;
    endtask

    task automatic test_null();
        out_ready = 1;
        drive(1, 3'b110);
        tick();
        drive(0, 3'b000);
        checks++;
        if ({out_valid, D3, D2, D1, D0, null_cnt} !== {5'b10000, 3'd1})
            $display("FAIL null_word: got v=%b d=%b n=%0d want v=1 d=0000 n=1",
                     out_valid, {D3, D2, D1, D0}, null_cnt);
        else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        drive(1, 3'b011);
        tick();
        drive(1, 3'b101);
        tick();
        drive(1, 3'b111);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({in_ready, out_valid, D3, D2, D1, D0} !== 6'b010010)
                $display("FAIL stall_%0d: got rdy=%b v=%b d=%b want rdy=0 v=1 d=0010",
                         i, in_ready, out_valid, {D3, D2, D1, D0});
            else passed++;
            tick();
        end
        out_ready = 1;
        tick();
        checks++;
        if ({out_valid, D3, D2, D1, D0} !== 5'b10100)
            $display("FAIL drain_1: got v=%b d=%b want v=1 d=0100", out_valid, {D3, D2, D1, D0});
        else passed++;
        tick();
        drive(0, 3'b000);
        checks++;
        if ({out_valid, D3, D2, D1, D0} !== 5'b11000)
            $display("FAIL drain_2: got v=%b d=%b want v=1 d=1000", out_valid, {D3, D2, D1, D0});
        else passed++;
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL drain_empty: got v=%b want 0", out_valid);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] prev;
        logic [1:0] c;
        out_ready = 1;
        c = 2'($urandom);
        drive(1, {c, 1'b1});
        prev = 4'(1 << c);
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({in_ready, out_valid, D3, D2, D1, D0} !== {2'b11, prev})
                $display("FAIL b2b_%0d: got rdy=%b v=%b d=%b want rdy=1 v=1 d=%b",
                         i, in_ready, out_valid, {D3, D2, D1, D0}, prev);
            else passed++;
            c = 2'($urandom);
            drive(1, {c, 1'b1});
            prev = 4'(1 << c);
            tick();
        end
        drive(0, 3'b000);
        tick();
    endtask

    task automatic test_saturation();
        int want;
        out_ready = 1;
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        for (int i = 0; i < 9; i++) begin
            drive(1, {2'($urandom), 1'b0});
            tick();
            want = i + 1 > NMAX ? NMAX : i + 1;
            checks++;
            if (null_cnt !== CNT_W'(want))
                $display("FAIL sat_%0d: got n=%0d want n=%0d", i, null_cnt, want);
            else passed++;
        end
        drive(1, 3'b000);
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        drive(0, 3'b000);
        checks++;
        if (null_cnt !== 3'd0) $display("FAIL clr_wins: got n=%0d want n=0", null_cnt);
        else passed++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), 3'($urandom));
            out_ready = 1'($urandom);
            cnt_clr = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if ({in_ready, out_valid, D3, D2, D1, D0, null_cnt} !==
                {q.size() < DEPTH, q.size() != 0, exp_d(), CNT_W'(mcnt)})
                $display("FAIL random_%0d: got rdy=%b v=%b d=%b n=%0d want rdy=%b v=%b d=%b n=%0d",
                         i, in_ready, out_valid, {D3, D2, D1, D0}, null_cnt,
                         q.size() < DEPTH, q.size() != 0, exp_d(), mcnt);
            else passed++;
            tick();
        end
        cnt_clr = 0;
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        drive(1, 3'b110);
        tick();
        drive(1, 3'b011);
        tick();
        rst_n = 0;
        #1;
        checks++;
        if (in_ready !== 1'b0) $display("FAIL mid_reset_ready: got %b want 0", in_ready);
        else passed++;
        tick();
        checks++;
        if ({out_valid, D3, D2, D1, D0, null_cnt} !== {5'b00000, 3'd0})
            $display("FAIL mid_reset_state: got v=%b d=%b n=%0d want v=0 d=0000 n=0",
                     out_valid, {D3, D2, D1, D0}, null_cnt);
        else passed++;
        rst_n = 1;
        drive(0, 3'b000);
        out_ready = 1;
        #1;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL mid_release_ready: got %b want 1", in_ready);
        else passed++;
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b0) $display("FAIL mid_no_emit: got v=%b want 0", out_valid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_null();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
